// File: rtl/mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_write_buffer: posted line-write FIFO between cache and main memory,  |
// | with read bypass and read-after-write forwarding from buffered entries.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cache_read_i,
   input  logic              cache_write_i,
   input  logic [ADDR_W-1:0] cache_addr_i,
   input  logic [DATA_W-1:0] cache_wdata_i,
   output logic [DATA_W-1:0] cache_rdata_o,
   output logic              cache_ready_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              buf_empty_o
);

   localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      U_IDLE    = 2'd0,
      U_RD_WAIT = 2'd1,
      U_ACK     = 2'd2
   } u_state_t;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_READ  = 2'd1,
      M_WRITE = 2'd2
   } m_state_t;

   u_state_t r_u_state, w_u_next;
   m_state_t r_m_state, w_m_next;

   logic [DEPTH-1:0]   r_valid;
   logic [ADDR_W-1:0]  r_addr [DEPTH];
   logic [DATA_W-1:0]  r_data [DEPTH];
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [c_CNT_W-1:0] r_count;
   logic               r_rd_pend;

   logic               r_mem_read;
   logic               r_mem_write;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_buf_empty;

   logic               w_full;
   logic               w_launch_rd;
   logic               w_launch_wr;
   logic               w_head_lock;
   logic               w_pop;
   logic               w_push;
   logic               w_coal;
   logic               w_fwd;
   logic               w_miss;
   logic               w_rd_done;
   logic               w_wr_hit;
   logic               w_rd_hit;
   logic [c_PTR_W-1:0] w_wr_idx;
   logic [c_PTR_W-1:0] w_rd_idx;

   assign w_full      = (r_count == c_FULL);
   // The head is locked both while its write is in flight and at the edge
   // that launches it, so a coalesce can never land in a line being sent.
   assign w_head_lock = (r_m_state == M_WRITE) || w_launch_wr;

   // Scan oldest to youngest so the last match seen is the youngest one.
   always_comb begin : p_match
      logic [c_PTR_W-1:0] v_idx;
      v_idx    = '0;
      w_wr_hit = 1'b0;
      w_wr_idx = '0;
      w_rd_hit = 1'b0;
      w_rd_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         v_idx = r_head + c_PTR_W'(k);
         if (r_valid[v_idx] && (r_addr[v_idx] == cache_addr_i)) begin
            w_rd_hit = 1'b1;
            w_rd_idx = v_idx;
            if (!(w_head_lock && (v_idx == r_head))) begin
               w_wr_hit = 1'b1;
               w_wr_idx = v_idx;
            end
         end
      end
   end

   // Upstream FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_u_state <= U_IDLE;
      end else begin
         r_u_state <= w_u_next;
      end
   end

   always_comb begin
      w_u_next  = r_u_state;
      w_push    = 1'b0;
      w_coal    = 1'b0;
      w_fwd     = 1'b0;
      w_miss    = 1'b0;
      w_rd_done = 1'b0;
      case (r_u_state)
         U_IDLE: begin
            if (cache_write_i) begin
               if (w_wr_hit) begin
                  w_coal   = 1'b1;
                  w_u_next = U_ACK;
               end else if (!w_full) begin
                  w_push   = 1'b1;
                  w_u_next = U_ACK;
               end
            end else if (cache_read_i) begin
               if (w_rd_hit) begin
                  w_fwd    = 1'b1;
                  w_u_next = U_ACK;
               end else begin
                  w_miss   = 1'b1;
                  w_u_next = U_RD_WAIT;
               end
            end
         end
         U_RD_WAIT: begin
            if ((r_m_state == M_READ) && mem_ready_i) begin
               w_rd_done = 1'b1;
               w_u_next  = U_ACK;
            end
         end
         U_ACK:   w_u_next = U_IDLE;
         default: w_u_next = U_IDLE;
      endcase
   end

   // Downstream FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_state <= M_IDLE;
      end else begin
         r_m_state <= w_m_next;
      end
   end

   always_comb begin
      w_m_next    = r_m_state;
      w_launch_rd = 1'b0;
      w_launch_wr = 1'b0;
      w_pop       = 1'b0;
      case (r_m_state)
         M_IDLE: begin
            if (r_rd_pend) begin
               w_launch_rd = 1'b1;
               w_m_next    = M_READ;
            end else if (r_count != '0) begin
               w_launch_wr = 1'b1;
               w_m_next    = M_WRITE;
            end
         end
         M_READ: begin
            if (mem_ready_i) begin
               w_m_next = M_IDLE;
            end
         end
         M_WRITE: begin
            if (mem_ready_i) begin
               w_pop    = 1'b1;
               w_m_next = M_IDLE;
            end
         end
         default: w_m_next = M_IDLE;
      endcase
   end

   // Entry payload needs no reset: r_valid alone qualifies it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= cache_addr_i;
         r_data[r_tail] <= cache_wdata_i;
      end
      if (w_coal) begin
         r_data[w_wr_idx] <= cache_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_rd_pend   <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_buf_empty <= 1'b1;
      end else begin
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end

         if (w_miss) begin
            r_rd_pend <= 1'b1;
         end else if (w_launch_rd) begin
            r_rd_pend <= 1'b0;
         end

         // The cache holds its address throughout a read miss.
         if (w_launch_rd) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= cache_addr_i;
         end else if (w_launch_wr) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_addr[r_head];
            r_mem_wdata <= r_data[r_head];
         end else if (mem_ready_i && (r_m_state != M_IDLE)) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
         end

         if (w_fwd) begin
            r_rdata <= r_data[w_rd_idx];
         end else if (w_rd_done) begin
            r_rdata <= mem_rdata_i;
         end

         r_buf_empty <= (r_count == '0) && !r_mem_write;
      end
   end

   assign cache_ready_o = (r_u_state == U_ACK);
   assign cache_rdata_o = r_rdata;
   assign mem_read_o    = r_mem_read;
   assign mem_write_o   = r_mem_write;
   assign mem_addr_o    = r_mem_addr;
   assign mem_wdata_o   = r_mem_wdata;
   assign buf_empty_o   = r_buf_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_write_buffer: directed bench with a latency-programmable memory.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_write_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cache_read_i;
   logic              cache_write_i;
   logic [ADDR_W-1:0] cache_addr_i;
   logic [DATA_W-1:0] cache_wdata_i;
   logic [DATA_W-1:0] cache_rdata_o;
   logic              cache_ready_o;
   logic              mem_read_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ready_i;
   logic              buf_empty_o;

   mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cache_read_i  (cache_read_i),
      .cache_write_i (cache_write_i),
      .cache_addr_i  (cache_addr_i),
      .cache_wdata_i (cache_wdata_i),
      .cache_rdata_o (cache_rdata_o),
      .cache_ready_o (cache_ready_o),
      .mem_read_o    (mem_read_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_ready_i   (mem_ready_i),
      .buf_empty_o   (buf_empty_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   bit auto_en = 1'b1;
   int lat     = 0;
   int wait_cnt = 0;

   logic              q_op   [$];
   logic [ADDR_W-1:0] q_addr [$];
   logic [DATA_W-1:0] q_data [$];

   task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat(input logic [7:0] s);
      return {16{s}};
   endfunction

   function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
      return {4{4'hC, a}};
   endfunction

   // Memory responder: acts on falling edges, completes after lat idle cycles.
   initial begin
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (mem_ready_i) begin
            mem_ready_i = 1'b0;
            wait_cnt    = 0;
         end else if ((mem_read_o || mem_write_o) && auto_en && rst_n) begin
            if (wait_cnt >= lat) begin
               mem_ready_i = 1'b1;
               wait_cnt    = 0;
               q_op.push_back(mem_write_o);
               q_addr.push_back(mem_addr_o);
               if (mem_write_o) begin
                  q_data.push_back(mem_wdata_o);
               end else begin
                  mem_rdata_i = mem_model(mem_addr_o);
                  q_data.push_back(mem_rdata_i);
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic clear_log();
      q_op.delete();
      q_addr.delete();
      q_data.delete();
   endtask

   task automatic do_req(input bit is_wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int max_cyc,
                         output int n, output bit ok, output logic [DATA_W-1:0] rd);
      cache_addr_i  = a;
      cache_wdata_i = d;
      cache_write_i = is_wr;
      cache_read_i  = !is_wr;
      ok = 1'b0;
      n  = 0;
      rd = '0;
      while (!ok && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
         if (cache_ready_o) ok = 1'b1;
      end
      if (ok) begin
         rd            = cache_rdata_o;
         cache_write_i = 1'b0;
         cache_read_i  = 1'b0;
         @(posedge clk); #1;
         check_val("ack_pulse_width", DATA_W'(cache_ready_o), DATA_W'(1'b0));
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!(buf_empty_o && !mem_read_o) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("drain_done", DATA_W'(buf_empty_o), DATA_W'(1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int                n;
      bit                ok;
      bit                hold_ok;
      bit                seen;
      int                nrd;
      logic [DATA_W-1:0] rd;

      rst_n         = 1'b0;
      cache_read_i  = 1'b0;
      cache_write_i = 1'b0;
      cache_addr_i  = '0;
      cache_wdata_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready",  DATA_W'(cache_ready_o), DATA_W'(1'b0));
      check_val("rst_mrd",    DATA_W'(mem_read_o),    DATA_W'(1'b0));
      check_val("rst_mwr",    DATA_W'(mem_write_o),   DATA_W'(1'b0));
      check_val("rst_maddr",  DATA_W'(mem_addr_o),    '0);
      check_val("rst_rdata",  cache_rdata_o,          '0);
      check_val("rst_empty",  DATA_W'(buf_empty_o),   DATA_W'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single write, memory completes after 3 cycles
      lat = 3;
      clear_log();
      do_req(1'b1, 28'h0000010, pat(8'hD1), 20, n, ok, rd);
      check_val("t1_ack", DATA_W'(ok), DATA_W'(1'b1));
      check_val("t1_ack_lat", DATA_W'(n), DATA_W'(1));
      hold_ok = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (!mem_write_o || mem_addr_o != 28'h0000010 || mem_wdata_o != pat(8'hD1))
            hold_ok = 1'b0;
         if (mem_ready_i) seen = 1'b1;
      end
      check_val("t1_ready_seen", DATA_W'(seen), DATA_W'(1'b1));
      check_val("t1_req_held", DATA_W'(hold_ok), DATA_W'(1'b1));
      @(posedge clk); #1;
      check_val("t1_mwr_drop", DATA_W'(mem_write_o), DATA_W'(1'b0));
      check_val("t1_empty_early", DATA_W'(buf_empty_o), DATA_W'(1'b0));
      @(posedge clk); #1;
      check_val("t1_empty", DATA_W'(buf_empty_o), DATA_W'(1'b1));

      // Fill to full with memory stalled; fifth write must wait
      lat     = 1;
      auto_en = 1'b0;
      clear_log();
      for (int i = 1; i <= 4; i++) begin
         do_req(1'b1, ADDR_W'(16 * i), pat(8'(8'hA0 + i)), 20, n, ok, rd);
         check_val("t2_ack", DATA_W'(ok), DATA_W'(1'b1));
      end
      do_req(1'b1, 28'h0000050, pat(8'hA5), 8, n, ok, rd);
      check_val("t2_full_stall", DATA_W'(ok), DATA_W'(1'b0));
      auto_en = 1'b1;
      do_req(1'b1, 28'h0000050, pat(8'hA5), 50, n, ok, rd);
      check_val("t2_fifth_ack", DATA_W'(ok), DATA_W'(1'b1));
      wait_idle();
      check_val("t2_nwrites", DATA_W'(q_op.size()), DATA_W'(5));
      for (int i = 0; i < 5 && i < q_op.size(); i++) begin
         check_val("t2_order_addr", DATA_W'(q_addr[i]), DATA_W'(16 * (i + 1)));
         check_val("t2_order_data", q_data[i], pat(8'(8'hA1 + i)));
      end

      // Coalescing behind an in-flight head
      auto_en = 1'b0;
      clear_log();
      do_req(1'b1, 28'h0000010, pat(8'hB1), 20, n, ok, rd);
      do_req(1'b1, 28'h0000020, pat(8'hD2), 20, n, ok, rd);
      do_req(1'b1, 28'h0000020, pat(8'hD3), 20, n, ok, rd);
      check_val("t3_ack", DATA_W'(ok), DATA_W'(1'b1));
      auto_en = 1'b1;
      wait_idle();
      check_val("t3_nwrites", DATA_W'(q_op.size()), DATA_W'(2));
      if (q_op.size() >= 2) begin
         check_val("t3_addr1", DATA_W'(q_addr[1]), DATA_W'(28'h0000020));
         check_val("t3_data1", q_data[1], pat(8'hD3));
      end

      // Forwarding: from the locked head, then from the youngest match
      auto_en = 1'b0;
      clear_log();
      do_req(1'b1, 28'h0000030, pat(8'hD4), 20, n, ok, rd);
      do_req(1'b0, 28'h0000030, '0, 20, n, ok, rd);
      check_val("t4_fwd_lat", DATA_W'(n), DATA_W'(1));
      check_val("t4_fwd_head", rd, pat(8'hD4));
      do_req(1'b1, 28'h0000030, pat(8'hD5), 20, n, ok, rd);
      do_req(1'b0, 28'h0000030, '0, 20, n, ok, rd);
      check_val("t4_fwd_young", rd, pat(8'hD5));
      auto_en = 1'b1;
      wait_idle();
      nrd = 0;
      foreach (q_op[i]) if (!q_op[i]) nrd++;
      check_val("t4_no_mem_read", DATA_W'(nrd), DATA_W'(0));
      check_val("t4_nwrites", DATA_W'(q_op.size()), DATA_W'(2));

      // Read miss bypasses queued writes but not the in-flight one
      auto_en = 1'b0;
      lat     = 2;
      clear_log();
      do_req(1'b1, 28'h0000010, pat(8'hE1), 20, n, ok, rd);
      do_req(1'b1, 28'h0000020, pat(8'hE2), 20, n, ok, rd);
      cache_addr_i = 28'h0000060;
      cache_read_i = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_val("t5_wait_ready", DATA_W'(cache_ready_o), DATA_W'(1'b0));
      check_val("t5_no_early_rd", DATA_W'(mem_read_o), DATA_W'(1'b0));
      auto_en = 1'b1;
      do_req(1'b0, 28'h0000060, '0, 60, n, ok, rd);
      check_val("t5_rd_ack", DATA_W'(ok), DATA_W'(1'b1));
      check_val("t5_rdata", rd, mem_model(28'h0000060));
      wait_idle();
      check_val("t5_nops", DATA_W'(q_op.size()), DATA_W'(3));
      if (q_op.size() >= 3) begin
         check_val("t5_op0", DATA_W'({q_op[0], q_addr[0]}), DATA_W'({1'b1, 28'h0000010}));
         check_val("t5_op1", DATA_W'({q_op[1], q_addr[1]}), DATA_W'({1'b0, 28'h0000060}));
         check_val("t5_op2", DATA_W'({q_op[2], q_addr[2]}), DATA_W'({1'b1, 28'h0000020}));
      end

      // Asynchronous reset while a write is in flight and an ack is showing
      auto_en = 1'b0;
      clear_log();
      do_req(1'b1, 28'h0000070, pat(8'hF1), 20, n, ok, rd);
      cache_addr_i  = 28'h0000080;
      cache_wdata_i = pat(8'hF2);
      cache_write_i = 1'b1;
      @(posedge clk); #1;
      check_val("t6_pre_ready", DATA_W'(cache_ready_o), DATA_W'(1'b1));
      check_val("t6_pre_mwr", DATA_W'(mem_write_o), DATA_W'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_async_mwr", DATA_W'(mem_write_o), DATA_W'(1'b0));
      check_val("t6_async_ready", DATA_W'(cache_ready_o), DATA_W'(1'b0));
      check_val("t6_async_empty", DATA_W'(buf_empty_o), DATA_W'(1'b1));
      cache_write_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      auto_en = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check_val("t6_no_reissue", DATA_W'(mem_write_o), DATA_W'(1'b0));
      check_val("t6_log_empty", DATA_W'(q_op.size()), DATA_W'(0));
      check_val("t6_empty", DATA_W'(buf_empty_o), DATA_W'(1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Sits between the cache controller's memory interface (128-bit line, 28-bit line address, level request / ready handshake) and main memory.
- Absorbs dirty-line writebacks into a small FIFO and acknowledges them quickly, so the cache can start its allocate read without waiting for the write to finish.
- Drains buffered writes to memory in the background.
- Reads go to memory ahead of queued writes; a read that hits a buffered line is served directly from the buffer.

Parameters:
- DEPTH, 4, number of line entries (power of two, ≥2)
- ADDR_W, 28, line address width
- DATA_W, 128, line data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cache_read_i  in  1  upstream line read request (level, held until cache_ready_o)
- cache_write_i  in  1  upstream line write request (level, held until cache_ready_o)
- cache_addr_i  in  ADDR_W  upstream line address
- cache_wdata_i  in  DATA_W  upstream write line
- cache_rdata_o  out  DATA_W  read line, valid while cache_ready_o=1
- cache_ready_o  out  1  one-cycle completion pulse for the current upstream request
- mem_read_o  out  1  memory read request (registered)
- mem_write_o  out  1  memory write request (registered)
- mem_addr_o  out  ADDR_W  memory line address (registered)
- mem_wdata_o  out  DATA_W  memory write line (registered)
- mem_rdata_i  in  DATA_W  memory read line, valid with mem_ready_i
- mem_ready_i  in  1  memory completion, one cycle
- buf_empty_o  out  1  no valid entries and no memory write in flight

Behaviour:
- Reset (async, rst_n=0):
  - All entries are invalidated; FIFO pointers and count are cleared.
  - Both FSMs go to idle.
  - cache_ready_o, mem_read_o and mem_write_o are 0; mem_addr_o, mem_wdata_o and cache_rdata_o are 0; buf_empty_o is 1.
  - Buffered data present at reset is discarded.
- Upstream FSM states are U_IDLE, U_RD_WAIT and U_ACK.
  - Read and write requests are never asserted together.
  - U_ACK drives cache_ready_o=1 for exactly one cycle, then returns to U_IDLE. Requests present during U_ACK are ignored, because the cache drops its request on seeing ready.
- Write accept, in U_IDLE with cache_write_i=1:
  - Coalesce: if a valid entry matches cache_addr_i and is not the head currently locked by an in-flight memory write, overwrite that entry's data.
  - Otherwise, if count<DEPTH, push at the tail.
  - Otherwise (full), stay in U_IDLE and retry each cycle.
  - The entry is written at the accepting edge; the FSM goes to U_ACK, so cache_ready_o rises one cycle after acceptance.
  - Full is evaluated on the pre-edge count. A write arriving in the same cycle that a drain retires is accepted on the following cycle.
- Read, in U_IDLE with cache_read_i=1:
  - Forward: if any valid entry matches, take the youngest match, load cache_rdata_o from it at the edge, and go to U_ACK (1-cycle latency, no memory access).
  - Miss: raise a pending-read flag and go to U_RD_WAIT.
  - When mem_ready_i completes the read, cache_rdata_o<=mem_rdata_i and the FSM goes to U_ACK.
- Downstream FSM states are M_IDLE, M_READ and M_WRITE.
  - In M_IDLE, a pending read has priority: register mem_read_o=1 and mem_addr_o=cache_addr_i, then go to M_READ.
  - Otherwise, if count>0, lock the head: register mem_write_o=1 with the head address and data, then go to M_WRITE.
  - mem_* outputs stay stable until mem_ready_i=1 is sampled. At that edge the request is deasserted and the FSM returns to M_IDLE; M_WRITE also pops the head there.
  - At least one idle cycle separates consecutive memory requests.
  - An in-flight write is never aborted. A read miss arriving during M_WRITE waits for that write to finish, then goes before the remaining entries.
- Pointers wrap modulo DEPTH; count stays within 0..DEPTH. A simultaneous push and pop leaves count unchanged.
- buf_empty_o = (count==0) && !mem_write_o, registered.
- Ordering: read-over-write bypass is safe only because forwarding covers every buffered address. The address compare must include all valid entries, including the locked head.

Test Plan:
- Reset, write 0x0000010/D1, mem_ready_i after 3 cycles -> cache_ready_o pulses 1 cycle after accept; mem_write_o with addr 0x0000010/D1 held until ready; buf_empty_o=1 two cycles after ready.
- mem_ready_i held 0; 5 writes to 0x10,0x20,0x30,0x40,0x50 -> 4 acks, 5th ready stays 0; release one mem_ready_i -> 5th acked; memory sees writes in order 0x10..0x50.
- Head 0x10 in flight; write 0x20/D2 then 0x20/D3 -> one memory write to 0x20 carrying D3, count peaks at 2.
- Write 0x30/D4, read 0x30 before drain -> cache_rdata_o=D4 with cache_ready_o 1 cycle after request; mem_read_o never asserts for 0x30.
- Buffer holds 0x10 (in flight) and 0x20; read 0x60 -> order on memory bus: write 0x10, read 0x60, write 0x20; cache_rdata_o=memory data for 0x60.
- Drive rst_n=0 mid M_WRITE -> mem_write_o, cache_ready_o drop immediately (async); buf_empty_o=1; after release no write reissued.
